// File: rtl/keypad_scanner_if.sv
// Keypad pin and lock-controller bundle for the 4x4 keypad scanner.
// master is the scanner side; slave is the keypad/consumer side.
`timescale 1ns/1ps
interface keypad_scanner_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [4:0] keycode;
  logic       newkey;

  modport master (
    input  row,
    output col,
    output keycode,
    output newkey
  );

  modport slave (
    output row,
    input  col,
    input  keycode,
    input  newkey
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low column drive, debounces
// single-key presses and releases, and emits a keycode with a newkey strobe.
`timescale 1ns/1ps
module keypad_scanner #(
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned SETTLE   = 2
) (
  input  logic            clk5,
  input  logic            reset,
  keypad_scanner_if.master kp
);

  typedef enum logic [2:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_PRESS,
    ST_HELD,
    ST_RELEASE
  } state_e;

  localparam logic [2:0] SETTLE_LAST = 3'(SETTLE - 1);
  localparam logic [3:0] DEB_COUNT   = 4'(DEBOUNCE);

  state_e     state_q;
  logic [1:0] col_idx_q;
  logic [3:0] col_q;
  logic [2:0] settle_q;
  logic [3:0] cnt_q;
  logic [3:0] idx_q;
  logic [3:0] pattern_q;
  logic [4:0] keycode_q;
  logic       newkey_q;

  logic       single_low;
  logic [1:0] row_idx;
  logic [1:0] col_inc;
  logic [3:0] cnt_inc;
  logic       row_idle;

  function automatic logic [3:0] col_mask(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  // A capture needs exactly one row low; several low rows are ghosting.
  always_comb begin
    single_low = 1'b1;
    row_idx    = 2'd0;
    case (kp.row)
      4'b1110: row_idx = 2'd0;
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: single_low = 1'b0;
    endcase
  end

  assign col_inc  = col_idx_q + 2'd1;
  assign cnt_inc  = cnt_q + 4'd1;
  assign row_idle = (kp.row == 4'b1111);

  // NOTE: reset is synchronous, so it lives inside the clocked block and only
  // takes effect on a rising edge; all state uses non-blocking assignments.
  always_ff @(posedge clk5) begin
    if (!reset) begin
      state_q   <= ST_SCAN;
      col_idx_q <= 2'd0;
      col_q     <= 4'b1110;
      settle_q  <= 3'd0;
      cnt_q     <= 4'd0;
      idx_q     <= 4'd0;
      pattern_q <= 4'd0;
      keycode_q <= 5'd0;
      newkey_q  <= 1'b0;
    end else begin
      // NOTE: default the strobe low each cycle so it can only ever be a pulse.
      newkey_q <= 1'b0;
      unique case (state_q)
        ST_SCAN: begin
          if (settle_q >= SETTLE_LAST) begin
            settle_q <= 3'd0;
            if (single_low) begin
              idx_q     <= {row_idx, col_idx_q};
              pattern_q <= kp.row;
              cnt_q     <= 4'd1;
              state_q   <= ST_DEBOUNCE;
            end else begin
              col_idx_q <= col_inc;
              col_q     <= col_mask(col_inc);
            end
          end else begin
            settle_q <= settle_q + 3'd1;
          end
        end

        ST_DEBOUNCE: begin
          if (kp.row == pattern_q) begin
            cnt_q <= cnt_inc;
            if (cnt_inc >= DEB_COUNT) begin
              state_q <= ST_PRESS;
              newkey_q  <= 1'b1;
              keycode_q <= {1'b1, idx_q};
            end
          end else begin
            cnt_q     <= 4'd0;
            settle_q  <= 3'd0;
            col_idx_q <= col_inc;
            col_q     <= col_mask(col_inc);
            state_q   <= ST_SCAN;
          end
        end

        ST_PRESS: begin
          cnt_q   <= 4'd0;
          state_q <= ST_HELD;
        end

        // Extra keys while held are ignored: no rollover, no second strobe.
        ST_HELD: begin
          if (row_idle) begin
            cnt_q   <= 4'd1;
            state_q <= ST_RELEASE;
          end
        end

        ST_RELEASE: begin
          if (!row_idle) begin
            cnt_q   <= 4'd0;
            state_q <= ST_HELD;
          end else if (cnt_inc >= DEB_COUNT) begin
            cnt_q     <= 4'd0;
            settle_q  <= 3'd0;
            keycode_q <= 5'd0;
            col_idx_q <= 2'd0;
            col_q     <= 4'b1110;
            state_q   <= ST_SCAN;
          end else begin
            cnt_q <= cnt_inc;
          end
        end

        default: begin
          state_q   <= ST_SCAN;
          col_idx_q <= 2'd0;
          col_q     <= 4'b1110;
          settle_q  <= 3'd0;
          cnt_q     <= 4'd0;
        end
      endcase
    end
  end

  assign kp.col     = col_q;
  assign kp.keycode = keycode_q;
  assign kp.newkey  = newkey_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: behavioural keypad matrix plus a
// keycode scoreboard fed at press time and drained on every newkey strobe.
`timescale 1ns/1ps
module tb_keypad_scanner;

  logic        clk5;
  logic        reset;
  logic [15:0] mask;
  logic        force_en;
  logic [3:0]  force_row;
  logic [3:0]  row_model;

  int n_vec;
  int n_err;
  logic [4:0] sb_q[$];

  keypad_scanner_if kp();

  keypad_scanner #(.DEBOUNCE(4), .SETTLE(2)) dut (
    .clk5  (clk5),
    .reset (reset),
    .kp    (kp)
  );

  initial clk5 = 1'b0;
  always #5 clk5 = ~clk5;

  // Pressed key (r,c) pulls row r low while column c is driven low.
  always_comb begin
    row_model = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (mask[r*4+c] && !kp.col[c]) row_model[r] = 1'b0;
    kp.row = force_en ? force_row : row_model;
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every strobe must match the oldest outstanding press.
  initial begin
    logic [4:0] exp_kc;
    forever begin
      @(negedge clk5);
      if (kp.newkey === 1'b1) begin
        if (sb_q.size() == 0) check("newkey_unexpected", 8'(kp.newkey), 8'd0);
        else begin
          exp_kc = sb_q.pop_front();
          check("sb_keycode", 8'(kp.keycode), 8'(exp_kc));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [3:0] col_of(input int idx);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << (idx % 4));
  endfunction

  // Called on the first cycle of a slot; checks two cycles per column.
  task automatic check_rotation(input int start, input int nslots);
    for (int i = 0; i < 2 * nslots; i++) begin
      if (i != 0) @(negedge clk5);
      check("col_rotation", 8'(kp.col), 8'(col_of(start + i / 2)));
    end
  endtask

  task automatic detect_key(input int k);
    logic [3:0] tgt;
    bit seen;
    tgt = col_of(k % 4);
    for (int i = 0; i < 40 && kp.col === tgt; i++) @(negedge clk5);
    mask[k] = 1'b1;
    sb_q.push_back(5'(16 + k));
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk5);
      if (kp.col === tgt) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("capture_timeout", 8'(kp.col), 8'(tgt));
    else begin
      @(posedge clk5);
      @(posedge clk5);
      for (int i = 0; i < 4; i++) begin
        @(negedge clk5);
        check("newkey_latency", 8'(kp.newkey), 8'(i == 3));
      end
      check("keycode_press", 8'(kp.keycode), 8'(16 + k));
      @(negedge clk5);
      check("newkey_width", 8'(kp.newkey), 8'd0);
    end
  endtask

  task automatic release_check(input int k);
    mask = '0;
    repeat (3) @(negedge clk5);
    check("release_hold", 8'(kp.keycode), 8'(16 + k));
    @(negedge clk5);
    check("release_keycode", 8'(kp.keycode), 8'd0);
    check("release_col", 8'(kp.col), 8'hE);
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    reset     = 1'b0;
    mask      = '0;
    force_en  = 1'b0;
    force_row = 4'hF;

    repeat (2) @(negedge clk5);
    check("reset_col", 8'(kp.col), 8'hE);
    check("reset_keycode", 8'(kp.keycode), 8'd0);
    check("reset_newkey", 8'(kp.newkey), 8'd0);
    reset = 1'b1;
    check_rotation(0, 5);

    // Clean press of key 2, long hold, then debounced release.
    detect_key(2);
    repeat (20) @(negedge clk5);
    check("key2_held", 8'(kp.keycode), 8'h12);
    release_check(2);

    // Bounce: only two matching samples after capture.
    mask[2] = 1'b1;
    for (int i = 0; i < 40 && kp.col !== 4'b1011; i++) @(negedge clk5);
    @(posedge clk5);
    @(posedge clk5);
    repeat (3) @(negedge clk5);
    mask = '0;
    @(negedge clk5);
    check("bounce_col", 8'(kp.col), 8'h7);
    check("bounce_keycode", 8'(kp.keycode), 8'd0);
    repeat (10) @(negedge clk5);
    check("bounce_idle", 8'(kp.keycode), 8'd0);

    // Ghost pattern on every column: scanning never stops.
    force_en  = 1'b1;
    force_row = 4'b1100;
    check_rotation(0, 8);
    force_en = 1'b0;
    check("ghost_keycode", 8'(kp.keycode), 8'd0);

    // Key 6, then a second key on the same column while held.
    detect_key(6);
    mask[2] = 1'b1;
    repeat (8) @(negedge clk5);
    check("key6_second", 8'(kp.keycode), 8'h16);
    release_check(6);

    // Release glitch, then reset while key 6 is still held.
    detect_key(6);
    mask = '0;
    repeat (2) @(negedge clk5);
    mask[6] = 1'b1;
    @(negedge clk5);
    mask = '0;
    repeat (3) @(negedge clk5);
    check("glitch_hold", 8'(kp.keycode), 8'h16);
    mask[6] = 1'b1;
    repeat (4) @(negedge clk5);
    check("glitch_reheld", 8'(kp.keycode), 8'h16);
    reset = 1'b0;
    @(negedge clk5);
    check("midreset_keycode", 8'(kp.keycode), 8'd0);
    check("midreset_col", 8'(kp.col), 8'hE);
    check("midreset_newkey", 8'(kp.newkey), 8'd0);
    reset = 1'b1;
    detect_key(6);
    release_check(6);

    repeat (4) @(negedge clk5);
    check("sb_drain", 8'(sb_q.size()), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Scans a 4x4 matrix keypad, debounces presses and releases, and presents each accepted press to the lock control FSM as a 5-bit keycode with a one-cycle newkey strobe. keycode[4] is the key-valid flag and keycode[3:0] is the key index (row*4 + col). It sits between the keypad pins and the stateMachine keycode/newkey inputs in the same clk5 domain.

Parameters:
DEBOUNCE, 4, consecutive matching samples required to accept a press and to accept a release (range 2..15).
SETTLE, 2, clk5 cycles each column is driven before its rows are sampled (range 1..7).

Ports:
clk5  input  1  system clock; all logic on the rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
row  input  4  keypad row sense, active-low (pulled up externally); assumed synchronised upstream
col  output  4  keypad column drive, one-hot active-low; col[c]=0 drives column c
keycode  output  5  {valid, index[3:0]}; valid=1 from accepted press until accepted release
newkey  output  1  one-cycle pulse per accepted press

Behaviour:
- Reset (reset=0 at clock edge): state=SCAN, column index=0, col=4'b1110, keycode=5'b00000, newkey=0, all counters=0. Reset overrides any state, including DEBOUNCE or HELD.
- SCAN: drive column index c for SETTLE cycles, then advance c = (c+1) mod 4 (3 wraps to 0). Sample row only on the last cycle of each slot.
  - Exactly one row bit low at sample (row r): capture idx = r*4 + c and the row pattern; freeze the column; go to DEBOUNCE with count=1.
  - All rows high or more than one row low: no capture; continue scanning.
- DEBOUNCE: sample row every cycle while the column stays frozen.
  - row equals captured pattern: count++. When count reaches DEBOUNCE, go to PRESS.
  - Mismatch: return to SCAN and resume at column (c+1) mod 4; no output change.
- PRESS (1 cycle): newkey=1, keycode={1'b1, idx}; go to HELD.
  - Latency: newkey is high in the cycle after the DEBOUNCE-th matching sample, i.e. DEBOUNCE cycles after capture.
- HELD: newkey=0; keycode holds; column stays frozen.
  - row all-high: go to RELEASE with count=1.
  - Any other row pattern, including a second key on the same column: ignored. No rollover, no second pulse.
- RELEASE: each cycle with row all-high, count++. Any low row bit returns to HELD and clears count.
  - When count reaches DEBOUNCE: keycode=5'b00000, column index=0, go to SCAN.
- newkey is high for exactly one cycle per accepted press and is never high in any other state.
- keycode changes only on PRESS entry, on release acceptance, and on reset.
- Counters: width 4 bits. They saturate-compare against the parameter and never wrap.
- col is always one-hot-low. It is never 4'b1111 and never has more than one bit low.

Test Plan:
- Reset: hold reset=0 for 2 cycles with row=1111 -> col=1110, keycode=00000, newkey=0. After release, col steps 1110,1101,1011,0111,1110 every 2 cycles (SETTLE=2).
- Clean press key 2: row=1110 whenever col=1011, held 20 cycles -> exactly one newkey pulse, 4 cycles after capture; keycode=10010 from the pulse cycle. Set row=1111 -> keycode=00000 after 4 cycles; col returns to 1110.
- Bounce rejection: row=1110 for only 2 cycles after capture on col=1011, then 1111 -> no newkey, keycode stays 00000, scanning resumes with col=0111.
- Key 6 plus held second key: row=1101 on col=1011 -> newkey pulse, keycode=10110. While held, add row0 low (row=1100) -> no further pulse; keycode stays 10110 until full release is debounced.
- Ghost rejection: row=1100 sampled on any column -> no capture, no newkey, col keeps rotating.
- Release glitch and mid-operation reset:
  - During RELEASE, a 1-cycle row=1101 -> stays HELD, keycode=10110.
  - Then reset=0 for 1 cycle -> keycode=00000, col=1110 next cycle.
  - Key still held after reset release -> re-detected; newkey pulses again with keycode=10110.
